// File: rtl/serial_pkg.sv
// Shared definitions for the serial line transmitter and future receiver.
// Line levels, FSM state encoding and counter sizing helper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_bit_tx_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while clear is high so each frame starts a fresh period.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = min1_clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  // Wrap at the end of each bit so the next bit starts at zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_bit_tx.sv
// Framed serial transmitter: start bit, LSB-first payload, stop bit.
// tx_out is registered from next-state so the line never glitches.
module serial_bit_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned IW = min1_clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 out_q, out_d;
  logic                 bit_end;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = !tx_ready;
  assign tx_done  = done_q;
  assign tx_out   = out_q;

  // Frame sequencing: accept, start, payload bits, stop.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shreg_d = tx_data;
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the coming cycle, taken from next state.
  always_comb begin
    out_d = LINE_IDLE;
    unique case (state_d)
      ST_START: out_d = START_BIT;
      ST_DATA:  out_d = shreg_d[0];
      ST_STOP:  out_d = STOP_BIT;
      default:  out_d = LINE_IDLE;
    endcase
  end

  // State registers; reset drops the frame and idles the line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: framing, handshake, async reset.
// Two instances: 4 clocks per bit and 1 clock per bit.
module tb_serial_bit_tx;

  logic       clk;
  logic       rst;
  logic [7:0] d0_data;
  logic       d0_valid;
  logic       d0_ready, d0_out, d0_busy, d0_done;
  logic [7:0] d1_data;
  logic       d1_valid;
  logic       d1_ready, d1_out, d1_busy, d1_done;

  int n_chk = 0;
  int n_bad = 0;

  serial_bit_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .tx_data (d0_data),
    .tx_valid(d0_valid),
    .tx_ready(d0_ready),
    .tx_out  (d0_out),
    .tx_busy (d0_busy),
    .tx_done (d0_done)
  );

  serial_bit_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .tx_data (d1_data),
    .tx_valid(d1_valid),
    .tx_ready(d1_ready),
    .tx_out  (d1_out),
    .tx_busy (d1_busy),
    .tx_done (d1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return in cycle 1 of its frame.
  task automatic start0(input logic [7:0] d);
    int n;
    d0_data  = d;
    d0_valid = 1'b1;
    n = 0;
    while (!d0_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("rdy_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Check cycles 1..41 of a CLKS_PER_BIT=4 frame; at cycle 20
  // the producer moves on to the next word (or drops valid).
  task automatic run_frame0(input logic [7:0] d, input logic [7:0] nd,
                            input logic nv);
    logic eo;
    for (int c = 1; c <= 41; c++) begin
      if (c <= 4)       eo = 1'b0;
      else if (c <= 36) eo = d[(c - 5) / 4];
      else              eo = 1'b1;
      chk("f0_out",   {31'd0, d0_out},   {31'd0, eo});
      chk("f0_busy",  {31'd0, d0_busy},  {31'd0, c <= 40});
      chk("f0_ready", {31'd0, d0_ready}, {31'd0, c == 41});
      chk("f0_done",  {31'd0, d0_done},  {31'd0, c == 41});
      if (c == 20) begin
        d0_data  = nd;
        d0_valid = nv;
      end
      if (c < 41) tick();
    end
  endtask

  initial begin
    logic [7:0] ref1;
    logic       eo;
    rst      = 1'b1;
    d0_data  = 8'h00;
    d0_valid = 1'b0;
    d1_data  = 8'h00;
    d1_valid = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out",   {31'd0, d0_out},   32'd1);
      chk("rst_ready", {31'd0, d0_ready}, 32'd1);
      chk("rst_busy",  {31'd0, d0_busy},  32'd0);
      chk("rst_done",  {31'd0, d0_done},  32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_out",  {31'd0, d0_out},  32'd1);
      chk("idle_out1", {31'd0, d1_out},  32'd1);
      chk("idle_done", {31'd0, d0_done}, 32'd0);
    end

    // Single frame 0xA5
    start0(8'hA5);
    d0_valid = 1'b0;
    run_frame0(8'hA5, 8'h00, 1'b0);
    tick();
    chk("a5_after_done", {31'd0, d0_done}, 32'd0);
    chk("a5_after_out",  {31'd0, d0_out},  32'd1);

    // Back-to-back 0x00 -> 0xFF, then 0x3C changed in mid-frame
    start0(8'h00);
    run_frame0(8'h00, 8'hFF, 1'b1);
    tick();
    run_frame0(8'hFF, 8'h3C, 1'b1);
    tick();
    run_frame0(8'h3C, 8'h00, 1'b0);
    tick();
    chk("b2b_idle_out",  {31'd0, d0_out},   32'd1);
    chk("b2b_idle_done", {31'd0, d0_done},  32'd0);
    chk("b2b_idle_rdy",  {31'd0, d0_ready}, 32'd1);

    // Async reset during data bit 3 of 0xF0 (bit 3 is 0)
    start0(8'hF0);
    d0_valid = 1'b0;
    for (int c = 1; c < 18; c++) tick();
    chk("ar_pre_out",  {31'd0, d0_out},  32'd0);
    chk("ar_pre_busy", {31'd0, d0_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out",  {31'd0, d0_out},   32'd1);
    chk("ar_busy", {31'd0, d0_busy},  32'd0);
    chk("ar_rdy",  {31'd0, d0_ready}, 32'd1);
    chk("ar_done", {31'd0, d0_done},  32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("ar_nodone", {31'd0, d0_done}, 32'd0);
      chk("ar_idle",   {31'd0, d0_out},  32'd1);
    end
    start0(8'h81);
    d0_valid = 1'b0;
    run_frame0(8'h81, 8'h00, 1'b0);
    tick();

    // One clock per bit, 0x01
    ref1     = 8'h01;
    d1_data  = ref1;
    d1_valid = 1'b1;
    tick();
    d1_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 1)      eo = 1'b0;
      else if (c <= 9) eo = ref1[c - 2];
      else             eo = 1'b1;
      chk("c1_out",  {31'd0, d1_out},  {31'd0, eo});
      chk("c1_done", {31'd0, d1_done}, {31'd0, c == 11});
      chk("c1_busy", {31'd0, d1_busy}, {31'd0, c <= 10});
      tick();
    end
    chk("c1_after", {31'd0, d1_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
